mult_sequencer: RTL and testbench

//  Byte-stream front end for the 36x36 multiplier datapath. Accepts 9 operand bytes from the MCU

---
 rtl/mult_seq_pkg.sv | 11 +
 rtl/mult_seq_byte_ser.sv | 34 +++
 rtl/mult_sequencer.sv | 69 ++++++
 tb/tb_mult_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared widths, byte counts and state encoding for the multiplier sequencer
package mult_seq_pkg;
  localparam int OPERAND_W = 36;
  localparam int BYTE_W = 8;
  localparam int PROD_W = 2 * OPERAND_W;
  localparam int IN_BYTES = (PROD_W + BYTE_W - 1) / BYTE_W;
  localparam int OUT_BYTES = (PROD_W + BYTE_W - 1) / BYTE_W;
  localparam int IN_CNT_W = $clog2(IN_BYTES);
  localparam int OUT_CNT_W = $clog2(OUT_BYTES);
  typedef enum logic [1:0] {LOAD, MULT, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/mult_seq_byte_ser.sv
// mult_seq_byte_ser: parallel-load product register shifted out MSB-first as a valid/ready byte stream
module mult_seq_byte_ser
  import mult_seq_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_load,
  input  logic [OUT_BYTES*BYTE_W-1:0] i_data,
  input  logic                        i_active,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic [BYTE_W-1:0]           o_data,
  output logic                        o_last
);
  localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(OUT_BYTES - 1);
  logic [OUT_BYTES*BYTE_W-1:0] shreg;
  logic [OUT_CNT_W-1:0] cnt;
  logic hs;
  assign o_valid = i_active;
  assign hs = o_valid & i_ready;
  assign o_last = hs && cnt == OUT_LAST;
  assign o_data = shreg[OUT_BYTES*BYTE_W-1 -: BYTE_W];
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      shreg <= '0;
      cnt <= '0;
    end else if (i_load) begin
      shreg <= i_data;
      cnt <= '0;
    end else if (hs) begin
      shreg <= shreg << BYTE_W;
      cnt <= o_last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: byte-stream front end that loads operands, runs the multiplier and drains the product
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int MULT_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [BYTE_W-1:0]    i_in_data,
  output logic [OPERAND_W-1:0] o_op_a,
  output logic [OPERAND_W-1:0] o_op_b,
  output logic                 o_mult_ce,
  input  logic [PROD_W-1:0]    i_mult_p,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [BYTE_W-1:0]    o_out_data,
  output logic                 o_busy
);
  localparam int LAT_W = $clog2(MULT_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MULT_LATENCY - 1);
  localparam logic [IN_CNT_W-1:0] IN_LAST = IN_CNT_W'(IN_BYTES - 1);
  state_t state, state_nx;
  logic [IN_CNT_W-1:0] in_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [PROD_W-1:0] operands;
  logic in_hs, in_last, lat_done, out_last;
  assign o_in_ready = state == LOAD;
  assign o_mult_ce = state == MULT;
  assign o_busy = state != LOAD;
  assign in_hs = i_in_valid & o_in_ready;
  assign in_last = in_hs && in_cnt == IN_LAST;
  assign lat_done = lat_cnt == LAT_LAST;
  assign o_op_a = operands[OPERAND_W-1:0];
  assign o_op_b = operands[PROD_W-1:OPERAND_W];
  always_comb begin
    state_nx = state;
    state_nx = state == LOAD ? (in_last ? MULT : LOAD) :
               state == MULT ? (lat_done ? CAPTURE : MULT) :
               state == CAPTURE ? DRAIN :
               (out_last ? LOAD : DRAIN);
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= LOAD;
      in_cnt <= '0;
      lat_cnt <= '0;
      operands <= '0;
    end else begin
      state <= state_nx;
      lat_cnt <= (state == MULT && !lat_done) ? lat_cnt + 1'b1 : '0;
      if (in_hs) begin
        operands <= {operands[PROD_W-BYTE_W-1:0], i_in_data};
        in_cnt <= in_last ? '0 : in_cnt + 1'b1;
      end
    end
  mult_seq_byte_ser u_ser (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (state == CAPTURE),
    .i_data   (i_mult_p),
    .i_active (state == DRAIN),
    .i_ready  (i_out_ready),
    .o_valid  (o_out_valid),
    .o_data   (o_out_data),
    .o_last   (out_last)
  );
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed checks of load, multiply timing, drain backpressure and reset behaviour
module tb_mult_sequencer;
  logic i_clk, i_reset, i_in_valid, o_in_ready, o_mult_ce, o_out_valid, i_out_ready, o_busy;
  logic [7:0] i_in_data, o_out_data;
  logic [35:0] o_op_a, o_op_b;
  logic [71:0] i_mult_p, p1, p2, got;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [71:0] PKT_53 = 72'h000000005000000003;
  localparam logic [71:0] PKT_FF = 72'hFFFFFFFFFFFFFFFFFF;
  localparam logic [71:0] PKT_76 = 72'h000000007000000006;

  mult_sequencer dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_op_a      (o_op_a),
    .o_op_b      (o_op_b),
    .o_mult_ce   (o_mult_ce),
    .i_mult_p    (i_mult_p),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;

  // Two-stage CE-gated multiplier model: product valid only after two enabled cycles
  always @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      p1 <= '0;
      p2 <= '0;
    end else if (o_mult_ce) begin
      p1 <= 72'(o_op_a) * 72'(o_op_b);
      p2 <= p1;
    end
  assign i_mult_p = p2;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    i_in_valid = 1;
    i_in_data = b;
    while (!o_in_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check("in_ready_wait", 72'(o_in_ready), 72'(1));
    check("busy_in_load", 72'(o_busy), 72'(0));
    @(negedge i_clk);
    i_in_valid = 0;
  endtask

  task automatic send_pkt(input logic [71:0] v, input int gap);
    for (int i = 0; i < 9; i++) begin
      send_byte(v[71-8*i -: 8]);
      if (i < 8) repeat (gap) @(negedge i_clk);
    end
  endtask

  // mode 0: always ready; 1: toggling; 2: toggling with a long stall mid-packet
  task automatic recv(input int mode, output logic [71:0] res);
    int hs = 0;
    logic stall = 0;
    logic [7:0] held = 0;
    logic rdy;
    res = '0;
    for (int t = 0; t < 20 && !o_out_valid; t++) @(negedge i_clk);
    for (int t = 0; t < 200 && hs < 9; t++) begin
      rdy = (mode == 0) || ((t % 2 == 0) && !(mode == 2 && t >= 6 && t < 11));
      i_out_ready = rdy;
      if (stall) check("stall_hold", 72'(o_out_data), 72'(held));
      if (hs > 0) check("valid_mid_pkt", 72'(o_out_valid), 72'(1));
      if (o_out_valid) check("in_ready_drain", 72'(o_in_ready), 72'(0));
      if (o_out_valid && rdy) begin
        res = {res[63:0], o_out_data};
        hs++;
      end
      stall = o_out_valid && !rdy;
      held = o_out_data;
      @(negedge i_clk);
    end
    i_out_ready = 0;
    check("out_hs_count", 72'(hs), 72'(9));
    check("valid_drop", 72'(o_out_valid), 72'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 72'(o_in_ready), 72'(1));
    check({tag, "_ce"}, 72'(o_mult_ce), 72'(0));
    check({tag, "_busy"}, 72'(o_busy), 72'(0));
    check({tag, "_out_valid"}, 72'(o_out_valid), 72'(0));
    check({tag, "_out_data"}, 72'(o_out_data), 72'(0));
    check({tag, "_op_a"}, 72'(o_op_a), 72'(0));
    check({tag, "_op_b"}, 72'(o_op_b), 72'(0));
  endtask

  initial begin
    i_reset = 1;
    i_in_valid = 0;
    i_in_data = 0;
    i_out_ready = 0;
    @(negedge i_clk);
    check_reset_outputs("por");
    i_reset = 0;
    @(negedge i_clk);
    check("in_ready_after_reset", 72'(o_in_ready), 72'(1));
    // 5 x 3 with exact CE and output latency
    send_pkt(PKT_53, 0);
    check("t1_op_b", 72'(o_op_b), 72'h5);
    check("t1_op_a", 72'(o_op_a), 72'h3);
    check("t1_ce_c1", 72'(o_mult_ce), 72'(1));
    check("t1_busy", 72'(o_busy), 72'(1));
    check("t1_in_ready", 72'(o_in_ready), 72'(0));
    check("t1_valid_c1", 72'(o_out_valid), 72'(0));
    @(negedge i_clk);
    check("t1_ce_c2", 72'(o_mult_ce), 72'(1));
    check("t1_valid_c2", 72'(o_out_valid), 72'(0));
    @(negedge i_clk);
    check("t1_ce_c3", 72'(o_mult_ce), 72'(0));
    check("t1_valid_c3", 72'(o_out_valid), 72'(0));
    @(negedge i_clk);
    check("t1_valid_c4", 72'(o_out_valid), 72'(1));
    check("t1_ce_drain", 72'(o_mult_ce), 72'(0));
    check("t1_first_byte", 72'(o_out_data), 72'h00);
    recv(0, got);
    check("t1_product", got, 72'h00000000000000000F);
    // all-ones operands
    send_pkt(PKT_FF, 0);
    check("t2_op_b", 72'(o_op_b), 72'hFFFFFFFFF);
    check("t2_op_a", 72'(o_op_a), 72'hFFFFFFFFF);
    recv(0, got);
    check("t2_product", got, 72'hFFFFFFFFE000000001);
    // backpressure with stall
    send_pkt(PKT_FF, 0);
    recv(2, got);
    check("t3_product", got, 72'hFFFFFFFFE000000001);
    // gapped input, stray valid while not loading
    send_pkt(PKT_53, 2);
    i_in_valid = 1;
    i_in_data = 8'hAA;
    recv(0, got);
    i_in_valid = 0;
    check("t4_product", got, 72'h00000000000000000F);
    check("t4_op_b", 72'(o_op_b), 72'h5);
    check("t4_op_a", 72'(o_op_a), 72'h3);
    // reset mid-load
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    i_reset = 1;
    #1;
    check_reset_outputs("rst_load");
    @(negedge i_clk);
    i_reset = 0;
    send_pkt(PKT_53, 0);
    recv(0, got);
    check("t5a_product", got, 72'h00000000000000000F);
    check("t5a_op_b", 72'(o_op_b), 72'h5);
    check("t5a_op_a", 72'(o_op_a), 72'h3);
    // reset mid-drain
    send_pkt(PKT_FF, 0);
    for (int t = 0; t < 20 && !o_out_valid; t++) @(negedge i_clk);
    check("t5b_valid_up", 72'(o_out_valid), 72'(1));
    i_out_ready = 1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_out_ready = 0;
    check("t5b_third_byte", 72'(o_out_data), 72'hFF);
    i_reset = 1;
    #1;
    check_reset_outputs("rst_drain");
    @(negedge i_clk);
    i_reset = 0;
    i_out_ready = 1;
    repeat (3) begin
      @(negedge i_clk);
      check("t5b_no_out_after_reset", 72'(o_out_valid), 72'(0));
    end
    i_out_ready = 0;
    // back-to-back transactions
    send_pkt(PKT_76, 0);
    check("t6_busy_mult", 72'(o_busy), 72'(1));
    recv(0, got);
    check("t6a_product", got, 72'h00000000000000002A);
    send_pkt(72'h0, 0);
    check("t6b_busy_mult", 72'(o_busy), 72'(1));
    check("t6b_op_a", 72'(o_op_a), 72'h0);
    recv(0, got);
    check("t6b_product", got, 72'h0);
    check("t6_busy_idle", 72'(o_busy), 72'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
